unpack_i64: RTL and testbench
=============================

// Module: unpack_i64
// PURPOSE
//  Signed LEB128 decoder for one 64-bit integer (WebAssembly i64 immediates).
//  Takes a 10-byte window starting at the first byte of the encoding.
//  Returns the sign-extended 64-bit value and the encoded length in bytes.
//  Sits after the byte-stream aligner in the decoder front end.
//  The length output drives the stream-pointer advance.
// PARAMETERS
//  none (widths fixed: 10 input bytes, 64-bit result, 4-bit length)
// PORTS
//  clk        input   1   single clock, rising edge
//  rst_n      input   1   asynchronous, active-low reset
//  in_valid   input   1   i0..i9 hold a window to decode this cycle
//  i0..i9     input   8   encoded bytes; i0 = first (least-significant group)
//  out_valid  output  1   o/len/err hold a decoded result
//  o          output  64  decoded value, two's complement
//  len        output  4   bytes consumed, 1..10; 0 when unterminated
//  err        output  1   no terminating byte within i0..i9
// BEHAVIOUR
//  - Reset (rst_n low, async): out_valid=0, o=0, len=0, err=0.
//  - Latency: 1 cycle, fully pipelined, no backpressure.
//  - Capture: on each clk rising edge with in_valid=1, o/len/err take the
//    decode of the current inputs and out_valid goes 1.
//  - Idle: when in_valid=0, out_valid goes 0 and o/len/err hold their value.
//  - Byte k (ik) is a continuation byte when ik[7]=1.
//  - Payload: ik[6:0] maps to o[7k+6:7k], clipped at bit 63.
//    For i9 only i9[0] is used (as o[63]); i9[7:1] are ignored.
//  - Length: len = (index of first byte with bit7=0) + 1.
//    Bytes after the terminator are ignored entirely.
//  - Sign extension: let t be the terminator index and n = 7*(t+1).
//    If n<64 and it[6]=1, o[63:n] are all 1; otherwise they are 0.
//    For t=9 there is no extension (bit 63 comes from i9[0]).
//  - Unterminated input (all i0..i9 have bit7=1): len=0, err=1.
//    o is the full 64-bit payload concatenation with no sign extension.
//  - Outputs never depend on the previous decode; back-to-back windows are
//    accepted every cycle.
//  - Reset asserted mid-stream clears out_valid immediately.
//    The first valid output after reset release needs a new in_valid.
//  - Decode is combinational priority logic: first-zero detect on bit7 of
//    i0..i9, then a per-length payload mask and sign-fill mux.
// TESTING
//  1. i0..i8=ff, i9=01 -> o=64'hffffffffffffffff, len=10, err=0.
//  2. i0..i3=80, i4=0c, i5=bc, i6=0b, i7..i9=00
//     -> o=64'h00000000c0000000, len=5 (bytes after i4 ignored).
//  3. i0=7f, rest=00 -> o=-1 (64'hffffffffffffffff), len=1.
//     i0=3f -> o=63, len=1.
//  4. i0=80, i1=7f -> o=64'hffffffffffffff80 (-128), len=2.
//     i0=80, i1=01 -> o=128, len=2.
//  5. All i0..i9=80 -> len=0, err=1, o=0.
//     Next cycle: i0=05 -> len=1, err=0, o=5.
//  6. Reset/handshake:
//     - assert rst_n=0 while in_valid streams -> out_valid, o, len = 0 at once;
//     - release -> out_valid=1 exactly 1 cycle after the next in_valid;
//     - in_valid=0 -> out_valid drops, o held.

Source files
------------

// File: rtl/unpack_i64.sv
// Signed LEB128 decoder for one WebAssembly i64 immediate: 10-byte window in,
// sign-extended 64-bit value, byte length and unterminated flag out, 1-cycle latency.
module unpack_i64 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         i0,
  input  logic [7:0]         i1,
  input  logic [7:0]         i2,
  input  logic [7:0]         i3,
  input  logic [7:0]         i4,
  input  logic [7:0]         i5,
  input  logic [7:0]         i6,
  input  logic [7:0]         i7,
  input  logic [7:0]         i8,
  input  logic [7:0]         i9,
  output logic               out_valid,
  output logic signed [63:0] o,
  output logic [3:0]         len,
  output logic               err
);

  logic [7:0]         w_byte [10];
  logic [9:0]         w_cont;
  logic signed [63:0] w_raw;
  logic signed [63:0] w_val;
  logic [3:0]         w_len;
  logic               w_err;
  logic               w_unused;

  logic               r_vld_p1;
  logic signed [63:0] r_val_p1;
  logic [3:0]         r_len_p1;
  logic               r_err_p1;

  // Keep a payload of n valid bits and replicate its top bit (sign) above it.
  function automatic logic signed [63:0] sign_fill(input logic signed [63:0] raw,
                                                   input logic              sgn,
                                                   input logic [6:0]        n);
    logic [63:0] mask;
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF << n);
    if (n >= 7'd64)
      return raw;
    else if (sgn)
      return raw | signed'(~mask);
    else
      return raw & signed'(mask);
  endfunction

  assign w_byte = '{i0, i1, i2, i3, i4, i5, i6, i7, i8, i9};

  // i9 contributes only its lowest payload bit (bit 63) and its continuation bit.
  assign w_raw    = {i9[0], i8[6:0], i7[6:0], i6[6:0], i5[6:0],
                     i4[6:0], i3[6:0], i2[6:0], i1[6:0], i0[6:0]};
  assign w_unused = &{1'b0, i9[6:1]};

  always_comb begin
    for (int k = 0; k < 10; k++) w_cont[k] = w_byte[k][7];
  end

  // First-zero priority: scanning high to low lets the lowest terminator win.
  always_comb begin
    w_len = 4'd0;
    w_err = 1'b1;
    w_val = w_raw;
    for (int k = 9; k >= 0; k--) begin
      if (!w_cont[k]) begin
        w_len = 4'(k + 1);
        w_err = 1'b0;
        w_val = sign_fill(w_raw, w_byte[k][6], 7'(7 * (k + 1)));
      end
    end
  end

  // Stage p1: registered decode result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_val_p1 <= '0;
      r_len_p1 <= '0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_val_p1 <= w_val;
        r_len_p1 <= w_len;
        r_err_p1 <= w_err;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign o         = r_val_p1;
  assign len       = r_len_p1;
  assign err       = r_err_p1;

endmodule

// File: tb/tb_unpack_i64.sv
// Self-checking bench for unpack_i64: directed LEB128 vectors, reset/handshake
// sequences and randomized windows compared against a byte-serial decode model.
module tb_unpack_i64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [79:0] win = '0;
  logic        out_valid;
  logic [63:0] o;
  logic [3:0]  len;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic        exp_vld = 1'b0;
  logic [63:0] exp_o = '0;
  logic [3:0]  exp_len = '0;
  logic        exp_err = 1'b0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  unpack_i64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .i0       (win[7:0]),
    .i1       (win[15:8]),
    .i2       (win[23:16]),
    .i3       (win[31:24]),
    .i4       (win[39:32]),
    .i5       (win[47:40]),
    .i6       (win[55:48]),
    .i7       (win[63:56]),
    .i8       (win[71:64]),
    .i9       (win[79:72]),
    .out_valid(out_valid),
    .o        (o),
    .len      (len),
    .err      (err)
  );

  // Textbook byte-serial signed LEB128 decode.
  function automatic logic [63:0] mdl(input logic [79:0] w, output logic [3:0] ln,
                                      output logic er);
    logic [63:0] acc;
    logic [7:0]  b;
    int          sh;
    acc = '0;
    sh  = 0;
    ln  = 4'd0;
    er  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b = w[8*k +: 8];
      acc = acc | ({57'd0, b[6:0]} << sh);
      sh = sh + 7;
      if (!b[7]) begin
        ln = 4'(k + 1);
        er = 1'b0;
        if (sh < 64 && b[6]) acc = acc | (64'hFFFF_FFFF_FFFF_FFFF << sh);
        break;
      end
    end
    return acc;
  endfunction

  function automatic logic [79:0] gen_win();
    logic [79:0] w;
    int          t;
    t = $urandom_range(0, 10);
    for (int k = 0; k < 10; k++) begin
      w[8*k +: 8] = 8'($urandom);
      if (k < t) w[8*k + 7] = 1'b1;
      else if (k == t) w[8*k + 7] = 1'b0;
    end
    return w;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference pipeline: expected outputs one cycle after each accepted window.
  always @(posedge clk or negedge rst_n) begin : model_p
    logic [3:0]  l;
    logic        e;
    logic [63:0] v;
    if (!rst_n) begin
      exp_vld <= 1'b0;
      exp_o   <= '0;
      exp_len <= '0;
      exp_err <= 1'b0;
    end else begin
      exp_vld <= in_valid;
      if (in_valid) begin
        v = mdl(win, l, e);
        exp_o   <= v;
        exp_len <= l;
        exp_err <= e;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
      check("cyc_o", o, exp_o);
      check("cyc_len", {60'd0, len}, {60'd0, exp_len});
      check("cyc_err", {63'd0, err}, {63'd0, exp_err});
    end
  end

  task automatic dir(input string nm, input logic [79:0] w, input logic [63:0] eo,
                     input logic [3:0] el, input logic ee);
    win = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_vld"}, {63'd0, out_valid}, 64'd1);
    check({nm, "_o"}, o, eo);
    check({nm, "_len"}, {60'd0, len}, {60'd0, el});
    check({nm, "_err"}, {63'd0, err}, {63'd0, ee});
  endtask

  task automatic pin(input string nm, input logic [79:0] w, input logic [63:0] eo,
                     input logic [3:0] el, input logic ee);
    logic [3:0]  l;
    logic        e;
    logic [63:0] v;
    v = mdl(w, l, e);
    check({nm, "_mdl_o"}, v, eo);
    check({nm, "_mdl_len"}, {60'd0, l}, {60'd0, el});
    check({nm, "_mdl_err"}, {63'd0, e}, {63'd0, ee});
  endtask

  initial begin
    pin("t1", {8'h01, {9{8'hff}}}, 64'hffff_ffff_ffff_ffff, 4'd10, 1'b0);
    pin("t2", 80'h0000_000b_bc0c_8080_8080, 64'h0000_0000_c000_0000, 4'd5, 1'b0);
    pin("t3a", 80'h7f, 64'hffff_ffff_ffff_ffff, 4'd1, 1'b0);
    pin("t4a", 80'h7f80, 64'hffff_ffff_ffff_ff80, 4'd2, 1'b0);
    pin("t5", {10{8'h80}}, 64'd0, 4'd0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {63'd0, out_valid}, 64'd0);
    check("rst_o", o, 64'd0);
    check("rst_len", {60'd0, len}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    dir("t1", {8'h01, {9{8'hff}}}, 64'hffff_ffff_ffff_ffff, 4'd10, 1'b0);
    dir("t2", 80'h0000_000b_bc0c_8080_8080, 64'h0000_0000_c000_0000, 4'd5, 1'b0);
    dir("t3a", 80'h7f, 64'hffff_ffff_ffff_ffff, 4'd1, 1'b0);
    dir("t3b", 80'h3f, 64'd63, 4'd1, 1'b0);
    dir("t4a", 80'h7f80, 64'hffff_ffff_ffff_ff80, 4'd2, 1'b0);
    dir("t4b", 80'h0180, 64'd128, 4'd2, 1'b0);
    dir("t5a", {10{8'h80}}, 64'd0, 4'd0, 1'b1);
    dir("t5b", 80'h05, 64'd5, 4'd1, 1'b0);
    dir("t9neg", {8'h7e, {9{8'h80}}}, 64'd0, 4'd10, 1'b0);

    in_valid = 1'b0;
    win = {10{8'hff}};
    @(posedge clk);
    #1;
    check("idle_vld", {63'd0, out_valid}, 64'd0);
    check("idle_o_hold", o, 64'd0);
    check("idle_len_hold", {60'd0, len}, 64'd10);

    in_valid = 1'b1;
    win = 80'h0180;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {63'd0, out_valid}, 64'd0);
    check("mid_rst_o", o, 64'd0);
    check("mid_rst_len", {60'd0, len}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rel_no_vld", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1;
    win = 80'h05;
    @(posedge clk);
    #1;
    check("rel_vld", {63'd0, out_valid}, 64'd1);
    check("rel_o", o, 64'd5);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      win = gen_win();
      @(posedge clk);
      #1;
    end

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
